din_serializer: RTL and testbench
=================================

DIN_SERIALIZER -- requirements
Module: din_serializer

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, serial word length in bits (legal range 2..32).
REQ-002 SHALL provide parameter MSB_FIRST, default 1, bit order: 1 = MSB first, 0 = LSB first.
REQ-003 SHALL provide parameter IDLE_LEVEL, default 0, ser_out level while no word is shifting.
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port in_data  input  WIDTH  parallel word to serialize.
REQ-007 SHALL have port in_valid  input  1  in_data valid.
REQ-008 SHALL have port in_ready  output  1  block can accept a word this cycle.
REQ-009 SHALL have port ser_out  output  1  serial bit stream, drives downstream FSM din.
REQ-010 SHALL have port ser_active  output  1  high while ser_out carries a data bit.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse on the last bit of a word.
REQ-012 SHALL have port frames_sent  output  16  count of fully shifted words.

Function
REQ-013 SHALL accept a word at a rising edge where in_valid=1 and in_ready=1, storing it in a one-entry hold register.
REQ-014 SHALL drive in_ready = !hold_full && !rst, from registered state only, with no combinational path from in_valid.
REQ-015 SHALL use states IDLE and SHIFT, together with a bit counter of width clog2(WIDTH) and a WIDTH-bit shift register.
REQ-016 SHALL, in IDLE with hold_full=1, at the next edge move hold into the shift register, clear hold_full, set bit counter=0, and enter SHIFT.
REQ-017 SHALL, in SHIFT, present exactly one bit per cycle for WIDTH consecutive cycles, in MSB-first or LSB-first order per MSB_FIRST.
REQ-018 SHALL drive ser_out directly from a shift-register bit (glitch-free) while in SHIFT, and drive ser_out=IDLE_LEVEL and ser_active=0 while in IDLE.
REQ-019 SHALL assert frame_done in the SHIFT cycle where the bit counter equals WIDTH-1.
REQ-020 SHALL, at the edge ending the last bit, load hold into the shift register and remain in SHIFT if hold_full=1, with no idle gap between words; otherwise it SHALL return to IDLE.
REQ-021 SHALL have a latency of 2 edges: a word accepted at edge N presents its first bit in the cycle after edge N+1 when the block is idle.
REQ-022 SHALL increment frames_sent at each frame_done edge, wrapping from 16'hFFFF to 16'h0000.
REQ-023 SHALL neither lose nor duplicate a word: a hold drain and a new acceptance cannot coincide because in_ready=0 while hold_full=1.
REQ-024 SHALL ignore in_data and in_valid whenever in_ready=0.

Reset
REQ-025 SHALL, while rst=1, set state=IDLE, hold_full=0, bit counter=0, shift register=0, frames_sent=0, ser_out=IDLE_LEVEL, ser_active=0, frame_done=0, and in_ready=0.
REQ-026 SHALL, on rst asserted mid-frame, discard both the shifting word and the held word, with no frame_done and no frames_sent increment.
REQ-027 SHALL assert in_ready=1 in the first cycle after rst deasserts.

Verification
REQ-028 SHALL be verified by: WIDTH=8, MSB_FIRST=1, send 8'hA5 -> ser_out 1,0,1,0,0,1,0,1 with ser_active high for 8 cycles; frame_done on the 8th bit; frames_sent=1.
REQ-029 SHALL be verified by: send 8'hA5 then 8'h3C with in_valid held high -> 16 contiguous ser_active cycles, second word 0,0,1,1,1,1,0,0, two frame_done pulses 8 cycles apart.
REQ-030 SHALL be verified by: MSB_FIRST=0, send 8'h01 -> ser_out 1 followed by seven 0s.
REQ-031 SHALL be verified by: rst asserted after 3 bits of 8'hFF with a second word held -> ser_out=0 and ser_active=0 next cycle, frames_sent=0, in_ready=1 after release, no further bits.
REQ-032 SHALL be verified by: preload frames_sent to 16'hFFFF via 65535 frames (or a force) then send one word -> frames_sent=16'h0000.
REQ-033 SHALL be verified by: in_valid=1 with data 8'h55 while in_ready=0 and data changing -> only the value present at the accepting edge is shifted out.

Source files
------------

// File: rtl/din_serializer.sv
// rtl/din_serializer.sv - parallel-to-serial word shifter with a one-entry hold register
// Feeds a downstream FSM din input one bit per clock, back-to-back when a word is held.
module din_serializer #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_active,
  output logic             frame_done,
  output logic [15:0]      frames_sent
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [15:0]      frames_q, frames_d;
  logic             accept;

  // in_ready depends only on registered state and rst, never on in_valid
  assign in_ready    = !hold_full_q && !rst;
  assign accept      = in_valid && in_ready;
  assign ser_active  = (state_q == S_SHIFT) && !rst;
  assign ser_out     = ser_active ? (MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0]) : IDLE_LEVEL;
  assign frame_done  = ser_active && (cnt_q == LAST_BIT);
  assign frames_sent = frames_q;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    frames_d    = frames_q;

    // accept never coincides with a drain: accept requires hold_full_q == 0
    if (accept) begin
      hold_d      = in_data;
      hold_full_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (hold_full_q) begin
          shift_d     = hold_q;
          hold_full_d = 1'b0;
          cnt_d       = '0;
          state_d     = S_SHIFT;
        end
      end
      default: begin
        shift_d = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0} : {1'b0, shift_q[WIDTH-1:1]};
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          frames_d = frames_q + 16'd1;
          cnt_d    = '0;
          if (hold_full_q) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      cnt_q       <= '0;
      shift_q     <= '0;
      frames_q    <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      frames_q    <= frames_d;
    end
  end

endmodule

// File: tb/tb_din_serializer.sv
// tb/tb_din_serializer.sv - scoreboard bench for din_serializer
// Expected bits are queued at the accepting edge and popped while ser_active is high.
module tb_din_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [7:0]  in_data, l_data;
  logic        in_valid, l_valid;
  logic        in_ready, ser_out, ser_active, frame_done;
  logic        l_ready, l_out, l_active, l_done;
  logic [15:0] frames_sent, l_frames;

  int errors = 0;
  int checks = 0;
  bit exp_q[$];
  logic [15:0] exp_frames;

  din_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .ser_out(ser_out), .ser_active(ser_active), .frame_done(frame_done), .frames_sent(frames_sent)
  );

  din_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .in_data(l_data), .in_valid(l_valid), .in_ready(l_ready),
    .ser_out(l_out), .ser_active(l_active), .frame_done(l_done), .frames_sent(l_frames)
  );

  task automatic push_word(input logic [7:0] w, input bit msb);
    for (int i = 0; i < 8; i++) exp_q.push_back(msb ? w[7-i] : w[i]);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; l_valid = 1'b0; l_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({in_ready, ser_out, ser_active, frame_done} !== 4'b0000) begin
      errors++; $display("FAIL reset_outputs: got %b expected 0000", {in_ready, ser_out, ser_active, frame_done});
    end
    checks++;
    if (frames_sent !== 16'h0000) begin
      errors++; $display("FAIL reset_frames: got %h expected 0000", frames_sent);
    end
    rst = 1'b0;
    exp_frames = 16'h0000;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || l_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: got %b%b expected 11", in_ready, l_ready);
    end
  endtask

  task automatic test_single();
    int first = -1, nact = 0, done_at = -1;
    bit b;
    @(negedge clk);
    in_data = 8'hA5; in_valid = 1'b1;
    push_word(in_data, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = 8'h00;
    exp_frames = exp_frames + 16'd1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (ser_active) begin
        if (first < 0) first = c;
        nact++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL single_extra_bit: got bit %b expected none", ser_out);
        end else begin
          b = exp_q.pop_front();
          if (ser_out !== b) begin errors++; $display("FAIL single_bit: got %b expected %b", ser_out, b); end
        end
      end
      if (frame_done) done_at = c;
    end
    checks++;
    if (first != 2) begin errors++; $display("FAIL single_latency: got %0d expected 2", first); end
    checks++;
    if (nact != 8) begin errors++; $display("FAIL single_active_len: got %0d expected 8", nact); end
    checks++;
    if (done_at != 9) begin errors++; $display("FAIL single_frame_done: got %0d expected 9", done_at); end
    checks++;
    if (frames_sent !== exp_frames) begin
      errors++; $display("FAIL single_frames: got %h expected %h", frames_sent, exp_frames);
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL single_missing: got %0d left expected 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [7:0] w[2] = '{8'hA5, 8'h3C};
    int idx = 0, nact = 0, first = -1, last = -1, d0 = -1, d1 = -1;
    bit acc, b;
    @(negedge clk);
    in_data = w[0]; in_valid = 1'b1;
    for (int c = 0; c < 30; c++) begin
      acc = in_valid && in_ready;
      if (acc) push_word(in_data, 1'b1);
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        exp_frames = exp_frames + 16'd1;
        if (idx < 2) in_data = w[idx];
        else in_valid = 1'b0;
      end
      @(negedge clk);
      if (ser_active) begin
        if (first < 0) first = c;
        last = c; nact++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_extra_bit: got bit %b expected none", ser_out);
        end else begin
          b = exp_q.pop_front();
          if (ser_out !== b) begin errors++; $display("FAIL b2b_bit: got %b expected %b at cycle %0d", ser_out, b, c); end
        end
      end
      if (frame_done) begin
        if (d0 < 0) d0 = c; else d1 = c;
      end
    end
    checks++;
    if (nact != 16 || last - first + 1 != 16) begin
      errors++; $display("FAIL b2b_contiguous: got %0d active over span %0d expected 16", nact, last - first + 1);
    end
    checks++;
    if (d1 - d0 != 8 || d0 < 0) begin
      errors++; $display("FAIL b2b_done_spacing: got %0d expected 8", d1 - d0);
    end
    checks++;
    if (frames_sent !== exp_frames) begin
      errors++; $display("FAIL b2b_frames: got %h expected %h", frames_sent, exp_frames);
    end
    exp_q.delete();
  endtask

  task automatic test_lsb_first();
    int nact = 0;
    bit b;
    @(negedge clk);
    l_data = 8'h01; l_valid = 1'b1;
    push_word(l_data, 1'b0);
    @(posedge clk); #1;
    l_valid = 1'b0; l_data = 8'hFF;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (l_active) begin
        nact++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL lsb_extra_bit: got bit %b expected none", l_out);
        end else begin
          b = exp_q.pop_front();
          if (l_out !== b) begin errors++; $display("FAIL lsb_bit: got %b expected %b", l_out, b); end
        end
      end
    end
    checks++;
    if (nact != 8 || l_frames !== 16'h0001) begin
      errors++; $display("FAIL lsb_frame: got %0d bits frames %h expected 8 bits frames 0001", nact, l_frames);
    end
    exp_q.delete();
  endtask

  task automatic test_ignore_not_ready();
    logic [7:0] w[2] = '{8'hF0, 8'h0F};
    int idx = 0, nbits = 0, blocked = 0;
    bit acc, b;
    @(negedge clk);
    in_data = w[0]; in_valid = 1'b1;
    for (int c = 0; c < 45; c++) begin
      if (in_valid && !in_ready) blocked++;
      acc = in_valid && in_ready;
      if (acc) push_word(in_data, 1'b1);
      @(posedge clk); #1;
      if (acc) begin idx++; exp_frames = exp_frames + 16'd1; end
      if (idx < 2) in_data = w[idx];
      else if (idx == 2) in_data = in_ready ? 8'h55 : 8'($urandom);
      else in_valid = 1'b0;
      @(negedge clk);
      if (ser_active) begin
        nbits++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL ignore_extra_bit: got bit %b expected none", ser_out);
        end else begin
          b = exp_q.pop_front();
          if (ser_out !== b) begin errors++; $display("FAIL ignore_bit: got %b expected %b at cycle %0d", ser_out, b, c); end
        end
      end
    end
    checks++;
    if (blocked < 5) begin errors++; $display("FAIL ignore_blocked_cycles: got %0d expected >=5", blocked); end
    checks++;
    if (nbits != 24 || exp_q.size() != 0) begin
      errors++; $display("FAIL ignore_bit_count: got %0d shifted %0d pending expected 24 and 0", nbits, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_wrap();
    int nact = 0;
    @(negedge clk);
    force dut.frames_d = 16'hFFFF;
    @(posedge clk); #1;
    release dut.frames_d;
    @(negedge clk);
    checks++;
    if (frames_sent !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload: got %h expected ffff", frames_sent); end
    in_data = 8'h81; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (ser_active) nact++;
    end
    checks++;
    if (nact != 8 || frames_sent !== 16'h0000) begin
      errors++; $display("FAIL wrap_frames: got %h after %0d bits expected 0000 after 8", frames_sent, nact);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] w[2] = '{8'hFF, 8'hAA};
    int idx = 0, nact = 0, stray = 0;
    bit acc;
    @(negedge clk);
    in_data = w[0]; in_valid = 1'b1;
    for (int c = 0; c < 20 && nact < 3; c++) begin
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx < 2) in_data = w[idx]; else in_valid = 1'b0;
      end
      @(negedge clk);
      if (ser_active) nact++;
    end
    checks++;
    if (nact != 3 || in_ready !== 1'b0) begin
      errors++; $display("FAIL rstmid_setup: got %0d bits ready %b expected 3 bits ready 0", nact, in_ready);
    end
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({ser_out, ser_active, frame_done} !== 3'b000 || frames_sent !== 16'h0000) begin
      errors++; $display("FAIL rstmid_outputs: got %b frames %h expected 000 frames 0000",
                         {ser_out, ser_active, frame_done}, frames_sent);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b expected 1", in_ready); end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ser_active || frame_done || ser_out) stray++;
    end
    checks++;
    if (stray != 0 || frames_sent !== 16'h0000) begin
      errors++; $display("FAIL rstmid_discard: got %0d stray cycles frames %h expected 0 and 0000", stray, frames_sent);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_lsb_first();
    test_ignore_not_ready();
    test_wrap();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
